uart_tx_sched: RTL and testbench
================================

Name: uart_tx_sched

Overview:
- Transmit scheduler that owns the single `uart` transmitter and shares it between two requesters:
  - the CPU I/O-write path, buffered through an internal FIFO;
  - a debug/monitor byte source using a req/ack handshake.
- Sits between the CPU I/O decode and the `uart` module.
- Sequences the uart wr/busy handshake and exposes FIFO status for CPU I/O reads.

Parameters:
- DEPTH, 16: FIFO entries. Power of two, 2..256.
- BUSY_WAIT, 4: cycles to wait for uart_busy to rise after a wr pulse before abandoning the wait.

Ports:
- clk  in  1  system clock
- reset  in  1  synchronous, active-high reset
- cpu_wr  in  1  one-cycle push strobe from the CPU I/O-write decode
- cpu_data  in  8  byte to push
- dbg_req  in  1  debug source requests transmit; held until dbg_ack
- dbg_data  in  8  debug byte; stable while dbg_req=1
- dbg_ack  out  1  one-cycle pulse: debug byte handed to the uart
- uart_wr  out  1  one-cycle write strobe to the uart
- uart_data  out  8  byte to the uart; valid while uart_wr=1, held until the next issue
- uart_busy  in  1  uart busy flag
- ovf_clr  in  1  clears the sticky overflow flag
- status  out  8  CPU-readable status: bit0 full, bit1 empty, bit2 overflow, bit3 tx_active, bits7:4 zero
- level  out  $clog2(DEPTH)+1  FIFO occupancy

Behaviour:
- Reset values:
  - uart_wr=0, uart_data=0, dbg_ack=0.
  - FIFO empty: level=0, so status=8'h02.
  - overflow=0, state=IDLE, rr_last=DBG, so the FIFO wins the first tie.
- FIFO:
  - Circular buffer with read/write pointers of log2(DEPTH) bits, wrap modulo DEPTH.
  - level counts 0..DEPTH; full=(level==DEPTH), empty=(level==0).
- Push:
  - On cpu_wr, if not full, store at wptr.
  - On cpu_wr when full, drop the byte and set overflow, unless a pop occurs in the same cycle; then accept it.
  - Push and pop in the same cycle leave level unchanged.
- Overflow flag is sticky:
  - ovf_clr clears it.
  - If ovf_clr and a new overflow coincide, the flag stays set.
- State machine, states IDLE, ISSUE, WAIT_HI, WAIT_LO:
  - IDLE: if uart_busy=0 and any request is pending, grant one source and go to ISSUE.
    - Request pending means FIFO non-empty or dbg_req=1.
    - Round-robin: if both request, grant the source not in rr_last. Update rr_last to the granted source.
  - ISSUE (1 cycle): uart_wr=1, uart_data=granted byte.
    - FIFO grant: pop (rptr++, level--) this cycle.
    - DBG grant: dbg_ack=1 this cycle.
    - Go to WAIT_HI.
  - WAIT_HI: wait for uart_busy=1, then go to WAIT_LO.
    - If BUSY_WAIT cycles elapse without busy, go to IDLE. The byte is treated as sent.
    - Counter: $clog2(BUSY_WAIT)+1 bits, cleared on entry.
  - WAIT_LO: when uart_busy=0, go to IDLE.
- Throughput constraint: minimum spacing between uart_wr pulses is 3 cycles (ISSUE, ≥1 WAIT, IDLE). No back-to-back uart_wr.
- tx_active = state≠IDLE.
- Outputs are registered except status and level, which are combinational from registers.
- dbg_req dropped before grant: the request is withdrawn and no ack is issued.
- Reset mid-operation:
  - Immediate return to IDLE; FIFO contents discarded; uart_wr deasserts the next cycle.
  - Any in-flight uart frame is not tracked after reset.

Test Plan:
1. Reset, then push 8'h41, 8'h42, 8'h43 on consecutive cycles. Uart model raises busy 1 cycle after wr, for 10 cycles.
   - Required: three uart_wr pulses carrying 41, 42, 43 in order.
   - Required: level 3→0; status ends 8'h02.
2. Push 17 bytes with DEPTH=16 and uart_busy held 1.
   - Required: level=16, status=8'h05 (full + overflow).
   - Then pulse ovf_clr, release busy. Required: the first 16 bytes are sent and the 17th is never sent.
3. FIFO holds 8'hAA, 8'hBB; dbg_req=1 with dbg_data=8'h55 held.
   - Required order: AA, 55, BB (round-robin).
   - Required: dbg_ack pulses exactly once, coincident with the 55 uart_wr.
4. Uart model never asserts busy; push 8'h10.
   - Required: one uart_wr, return to IDLE after BUSY_WAIT=4 wait cycles.
   - A second push is then issued normally.
5. Full FIFO with cpu_wr coincident with the ISSUE pop.
   - Required: the byte is accepted, level stays 16, overflow stays 0.
6. Assert reset during WAIT_LO with 5 bytes queued.
   - Required next cycle: level=0, status=8'h02, uart_wr=0.
   - Required: no further uart_wr until a new push.

Source files
------------

// File: rtl/uart_tx_sched.sv
// Transmit scheduler sharing one uart between a CPU-side FIFO and a debug req/ack source.
// Round-robin arbitration in IDLE, registered one-cycle issue, then busy handshake tracking.
module uart_tx_sched #(
    parameter int unsigned DEPTH     = 16,
    parameter int unsigned BUSY_WAIT = 4
) (
    input  logic                     clk,
    input  logic                     reset,
    input  logic                     cpu_wr,
    input  logic [7:0]               cpu_data,
    input  logic                     dbg_req,
    input  logic [7:0]               dbg_data,
    output logic                     dbg_ack,
    output logic                     uart_wr,
    output logic [7:0]               uart_data,
    input  logic                     uart_busy,
    input  logic                     ovf_clr,
    output logic [7:0]               status,
    output logic [$clog2(DEPTH):0]   level
);

    localparam int unsigned PW = $clog2(DEPTH);
    localparam int unsigned LW = PW + 1;
    localparam int unsigned CW = $clog2(BUSY_WAIT) + 1;

    typedef enum logic [1:0] {IDLE, ISSUE, WAIT_HI, WAIT_LO} stateT;

    stateT          state;
    stateT          nextState;
    logic [7:0]     mem [DEPTH];
    logic [PW-1:0]  wPtr;
    logic [PW-1:0]  rPtr;
    logic [LW-1:0]  count;
    logic           overflow;
    logic           grantDbg;
    logic           rrLastDbg;
    logic [CW-1:0]  waitCnt;

    logic full;
    logic empty;
    logic pop;
    logic push;
    logic ovfSet;
    logic pickDbg;
    logic grantNow;
    logic txActive;

    assign full     = (count == LW'(DEPTH));
    assign empty    = (count == '0);
    assign txActive = (state != IDLE);
    assign pop      = (state == ISSUE) && !grantDbg;
    // A push into a full FIFO is still accepted when the issue pop frees a slot this cycle.
    assign push     = cpu_wr && (!full || pop);
    assign ovfSet   = cpu_wr && full && !pop;
    assign pickDbg  = dbg_req && (empty || !rrLastDbg);
    assign grantNow = (state == IDLE) && !uart_busy && (!empty || dbg_req);

    assign status = {4'b0000, txActive, overflow, empty, full};
    assign level  = count;

    always_comb begin
        nextState = state;
        case (state)
            IDLE:    if (grantNow) nextState = ISSUE;
            ISSUE:   nextState = WAIT_HI;
            WAIT_HI: begin
                if (uart_busy)
                    nextState = WAIT_LO;
                else if (waitCnt == CW'(BUSY_WAIT - 1))
                    nextState = IDLE;
            end
            WAIT_LO: if (!uart_busy) nextState = IDLE;
            default: nextState = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (push)
            mem[wPtr] <= cpu_data;
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state     <= IDLE;
            wPtr      <= '0;
            rPtr      <= '0;
            count     <= '0;
            overflow  <= 1'b0;
            grantDbg  <= 1'b0;
            rrLastDbg <= 1'b1;
            waitCnt   <= '0;
            uart_wr   <= 1'b0;
            uart_data <= '0;
            dbg_ack   <= 1'b0;
        end else begin
            state   <= nextState;
            uart_wr <= grantNow;
            dbg_ack <= grantNow && pickDbg;

            if (grantNow) begin
                grantDbg  <= pickDbg;
                rrLastDbg <= pickDbg;
                uart_data <= pickDbg ? dbg_data : mem[rPtr];
            end

            if (push)
                wPtr <= wPtr + PW'(1);
            if (pop)
                rPtr <= rPtr + PW'(1);
            if (push && !pop)
                count <= count + LW'(1);
            else if (pop && !push)
                count <= count - LW'(1);

            if (ovfSet)
                overflow <= 1'b1;
            else if (ovf_clr)
                overflow <= 1'b0;

            if (state == ISSUE)
                waitCnt <= '0;
            else if (state == WAIT_HI && !uart_busy)
                waitCnt <= waitCnt + CW'(1);
        end
    end

endmodule

// File: tb/tb_uart_tx_sched.sv
// Directed bench for uart_tx_sched: a small uart busy model plus scenario tasks.
module tb_uart_tx_sched;

    logic       clk = 1'b0;
    logic       reset = 1'b1;
    logic       cpu_wr = 1'b0;
    logic [7:0] cpu_data = '0;
    logic       dbg_req = 1'b0;
    logic [7:0] dbg_data = '0;
    logic       dbg_ack;
    logic       uart_wr;
    logic [7:0] uart_data;
    logic       uart_busy;
    logic       ovf_clr = 1'b0;
    logic [7:0] status;
    logic [4:0] level;

    int testsRun = 0;
    int testsFailed = 0;

    // busyMode: 0 = uart model, 1 = forced busy, 2 = never busy
    int         busyMode = 1;
    int         busyCnt = 0;
    bit         armed = 1'b0;
    logic [7:0] wrQ[$];
    int         ackCount = 0;
    int         ackMisaligned = 0;
    int         spacingErr = 0;
    int         sinceWr = 100;
    logic [7:0] dbgByteExp = 8'h55;

    assign uart_busy = (busyMode == 1) ? 1'b1 : (busyMode == 2) ? 1'b0 : (busyCnt != 0);

    uart_tx_sched #(.DEPTH(16), .BUSY_WAIT(4)) dut (
        .clk(clk), .reset(reset), .cpu_wr(cpu_wr), .cpu_data(cpu_data),
        .dbg_req(dbg_req), .dbg_data(dbg_data), .dbg_ack(dbg_ack),
        .uart_wr(uart_wr), .uart_data(uart_data), .uart_busy(uart_busy),
        .ovf_clr(ovf_clr), .status(status), .level(level)
    );

    always #5 clk = ~clk;

    // Uart model and output monitor, sampled 1 time unit after each rising edge.
    initial forever begin
        @(posedge clk);
        #1;
        if (reset) begin
            busyCnt = 0;
            armed = 1'b0;
            sinceWr = 100;
        end else begin
            if (busyCnt != 0) busyCnt = busyCnt - 1;
            if (armed) begin
                busyCnt = 10;
                armed = 1'b0;
            end
            if (uart_wr) begin
                armed = 1'b1;
                wrQ.push_back(uart_data);
                if (sinceWr < 3) spacingErr = spacingErr + 1;
                sinceWr = 0;
            end else if (sinceWr < 100) begin
                sinceWr = sinceWr + 1;
            end
            if (dbg_ack) begin
                ackCount = ackCount + 1;
                if (!(uart_wr && uart_data == dbgByteExp)) ackMisaligned = ackMisaligned + 1;
            end
        end
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    task automatic doReset();
        @(negedge clk);
        reset = 1'b1;
        cpu_wr = 1'b0;
        dbg_req = 1'b0;
        ovf_clr = 1'b0;
        @(negedge clk);
        reset = 1'b0;
        wrQ.delete();
        ackCount = 0;
        ackMisaligned = 0;
    endtask

    task automatic waitWr(input int n, input int budget);
        for (int i = 0; i < budget && wrQ.size() < n; i++) @(negedge clk);
    endtask

    task automatic test_reset();
        @(negedge clk);
        reset = 1'b1;
        @(negedge clk);
        testsRun++;
        if (uart_wr !== 1'b0) begin testsFailed++; $display("FAIL reset_uart_wr got %b want 0", uart_wr); end
        testsRun++;
        if (uart_data !== 8'h00) begin testsFailed++; $display("FAIL reset_uart_data got %h want 00", uart_data); end
        testsRun++;
        if (dbg_ack !== 1'b0) begin testsFailed++; $display("FAIL reset_dbg_ack got %b want 0", dbg_ack); end
        testsRun++;
        if (level !== 5'd0) begin testsFailed++; $display("FAIL reset_level got %0d want 0", level); end
        testsRun++;
        if (status !== 8'h02) begin testsFailed++; $display("FAIL reset_status got %h want 02", status); end
        reset = 1'b0;
    endtask

    task automatic test_basic_order();
        logic [7:0] exp [3];
        exp[0] = 8'h41; exp[1] = 8'h42; exp[2] = 8'h43;
        doReset();
        busyMode = 1;
        for (int i = 0; i < 3; i++) begin
            cpu_wr = 1'b1;
            cpu_data = exp[i];
            @(negedge clk);
        end
        cpu_wr = 1'b0;
        testsRun++;
        if (level !== 5'd3) begin testsFailed++; $display("FAIL t1_level3 got %0d want 3", level); end
        testsRun++;
        if (status !== 8'h00) begin testsFailed++; $display("FAIL t1_status_mid got %h want 00", status); end
        busyMode = 0;
        waitWr(3, 200);
        repeat (20) @(negedge clk);
        testsRun++;
        if (wrQ.size() != 3) begin
            testsFailed++; $display("FAIL t1_count got %0d want 3", wrQ.size());
        end else begin
            for (int i = 0; i < 3; i++) begin
                testsRun++;
                if (wrQ[i] !== exp[i]) begin testsFailed++; $display("FAIL t1_byte%0d got %h want %h", i, wrQ[i], exp[i]); end
            end
        end
        testsRun++;
        if (level !== 5'd0) begin testsFailed++; $display("FAIL t1_level_end got %0d want 0", level); end
        testsRun++;
        if (status !== 8'h02) begin testsFailed++; $display("FAIL t1_status_end got %h want 02", status); end
    endtask

    task automatic test_overflow();
        int errs;
        doReset();
        busyMode = 1;
        for (int i = 0; i < 17; i++) begin
            cpu_wr = 1'b1;
            cpu_data = 8'h60 + 8'(i);
            @(negedge clk);
        end
        cpu_wr = 1'b0;
        testsRun++;
        if (level !== 5'd16) begin testsFailed++; $display("FAIL t2_level_full got %0d want 16", level); end
        testsRun++;
        if (status !== 8'h05) begin testsFailed++; $display("FAIL t2_status_ovf got %h want 05", status); end
        ovf_clr = 1'b1;
        @(negedge clk);
        ovf_clr = 1'b0;
        testsRun++;
        if (status !== 8'h01) begin testsFailed++; $display("FAIL t2_status_clr got %h want 01", status); end
        busyMode = 0;
        waitWr(16, 600);
        repeat (60) @(negedge clk);
        testsRun++;
        if (wrQ.size() != 16) begin
            testsFailed++; $display("FAIL t2_count got %0d want 16", wrQ.size());
        end else begin
            errs = 0;
            for (int i = 0; i < 16; i++)
                if (wrQ[i] !== 8'h60 + 8'(i)) errs++;
            testsRun++;
            if (errs != 0) begin testsFailed++; $display("FAIL t2_order got %0d wrong bytes want 0", errs); end
        end
        testsRun++;
        if (level !== 5'd0) begin testsFailed++; $display("FAIL t2_level_end got %0d want 0", level); end
    endtask

    task automatic test_dbg_withdraw();
        doReset();
        busyMode = 1;
        dbg_data = 8'h33;
        dbg_req = 1'b1;
        repeat (3) @(negedge clk);
        dbg_req = 1'b0;
        busyMode = 0;
        repeat (20) @(negedge clk);
        testsRun++;
        if (ackCount != 0) begin testsFailed++; $display("FAIL tw_ack got %0d want 0", ackCount); end
        testsRun++;
        if (wrQ.size() != 0) begin testsFailed++; $display("FAIL tw_wr got %0d want 0", wrQ.size()); end
    endtask

    task automatic test_round_robin();
        logic [7:0] exp [3];
        exp[0] = 8'hAA; exp[1] = 8'h55; exp[2] = 8'hBB;
        doReset();
        busyMode = 1;
        cpu_wr = 1'b1; cpu_data = 8'hAA;
        @(negedge clk);
        cpu_data = 8'hBB;
        @(negedge clk);
        cpu_wr = 1'b0;
        dbgByteExp = 8'h55;
        dbg_data = 8'h55;
        dbg_req = 1'b1;
        busyMode = 0;
        for (int i = 0; i < 300 && wrQ.size() < 3; i++) begin
            @(negedge clk);
            if (dbg_ack) dbg_req = 1'b0;
        end
        repeat (20) @(negedge clk);
        dbg_req = 1'b0;
        testsRun++;
        if (wrQ.size() != 3) begin
            testsFailed++; $display("FAIL t3_count got %0d want 3", wrQ.size());
        end else begin
            for (int i = 0; i < 3; i++) begin
                testsRun++;
                if (wrQ[i] !== exp[i]) begin testsFailed++; $display("FAIL t3_byte%0d got %h want %h", i, wrQ[i], exp[i]); end
            end
        end
        testsRun++;
        if (ackCount != 1) begin testsFailed++; $display("FAIL t3_ack_count got %0d want 1", ackCount); end
        testsRun++;
        if (ackMisaligned != 0) begin testsFailed++; $display("FAIL t3_ack_align got %0d want 0", ackMisaligned); end
    endtask

    task automatic test_busy_timeout();
        int active;
        bit seen;
        doReset();
        busyMode = 2;
        cpu_wr = 1'b1; cpu_data = 8'h10;
        @(negedge clk);
        cpu_wr = 1'b0;
        seen = 1'b0;
        for (int i = 0; i < 10 && !seen; i++) begin
            @(negedge clk);
            if (uart_wr) seen = 1'b1;
        end
        testsRun++;
        if (seen !== 1'b1 || uart_data !== 8'h10) begin
            testsFailed++; $display("FAIL t4_issue got wr=%b data=%h want wr=1 data=10", seen, uart_data);
        end
        active = 0;
        for (int i = 0; i < 10; i++) begin
            @(negedge clk);
            if (status[3]) active++;
            else break;
        end
        testsRun++;
        if (active != 4) begin testsFailed++; $display("FAIL t4_wait_cycles got %0d want 4", active); end
        cpu_wr = 1'b1; cpu_data = 8'h20;
        @(negedge clk);
        cpu_wr = 1'b0;
        waitWr(2, 30);
        testsRun++;
        if (wrQ.size() != 2) begin
            testsFailed++; $display("FAIL t4_second_count got %0d want 2", wrQ.size());
        end else begin
            testsRun++;
            if (wrQ[1] !== 8'h20) begin testsFailed++; $display("FAIL t4_second_byte got %h want 20", wrQ[1]); end
        end
    endtask

    task automatic test_full_push_pop();
        doReset();
        busyMode = 1;
        for (int i = 0; i < 16; i++) begin
            cpu_wr = 1'b1;
            cpu_data = 8'h80 + 8'(i);
            @(negedge clk);
        end
        cpu_wr = 1'b0;
        testsRun++;
        if (status !== 8'h01) begin testsFailed++; $display("FAIL t5_status_full got %h want 01", status); end
        busyMode = 0;
        @(negedge clk);
        testsRun++;
        if (uart_wr !== 1'b1) begin testsFailed++; $display("FAIL t5_issue got %b want 1", uart_wr); end
        cpu_wr = 1'b1;
        cpu_data = 8'hEE;
        @(negedge clk);
        cpu_wr = 1'b0;
        testsRun++;
        if (level !== 5'd16) begin testsFailed++; $display("FAIL t5_level got %0d want 16", level); end
        testsRun++;
        if (status !== 8'h09) begin testsFailed++; $display("FAIL t5_status got %h want 09", status); end
        waitWr(17, 600);
        testsRun++;
        if (wrQ.size() != 17) begin
            testsFailed++; $display("FAIL t5_count got %0d want 17", wrQ.size());
        end else begin
            testsRun++;
            if (wrQ[0] !== 8'h80 || wrQ[16] !== 8'hEE) begin
                testsFailed++; $display("FAIL t5_bytes got %h..%h want 80..ee", wrQ[0], wrQ[16]);
            end
        end
        repeat (20) @(negedge clk);
    endtask

    task automatic test_reset_mid();
        doReset();
        busyMode = 1;
        for (int i = 0; i < 6; i++) begin
            cpu_wr = 1'b1;
            cpu_data = 8'hC0 + 8'(i);
            @(negedge clk);
        end
        cpu_wr = 1'b0;
        busyMode = 0;
        repeat (3) @(negedge clk);
        testsRun++;
        if (level !== 5'd5 || status[3] !== 1'b1) begin
            testsFailed++; $display("FAIL t6_pre got level=%0d act=%b want level=5 act=1", level, status[3]);
        end
        reset = 1'b1;
        @(negedge clk);
        testsRun++;
        if (level !== 5'd0) begin testsFailed++; $display("FAIL t6_level got %0d want 0", level); end
        testsRun++;
        if (status !== 8'h02) begin testsFailed++; $display("FAIL t6_status got %h want 02", status); end
        testsRun++;
        if (uart_wr !== 1'b0) begin testsFailed++; $display("FAIL t6_uart_wr got %b want 0", uart_wr); end
        reset = 1'b0;
        repeat (40) @(negedge clk);
        testsRun++;
        if (wrQ.size() != 1) begin testsFailed++; $display("FAIL t6_quiet got %0d want 1", wrQ.size()); end
        cpu_wr = 1'b1; cpu_data = 8'h77;
        @(negedge clk);
        cpu_wr = 1'b0;
        waitWr(2, 40);
        testsRun++;
        if (wrQ.size() != 2 || wrQ[wrQ.size()-1] !== 8'h77) begin
            testsFailed++; $display("FAIL t6_new_push got n=%0d want n=2 last=77", wrQ.size());
        end
        repeat (20) @(negedge clk);
    endtask

    initial begin
        test_reset();
        test_basic_order();
        test_overflow();
        test_dbg_withdraw();
        test_round_robin();
        test_busy_timeout();
        test_full_push_pop();
        test_reset_mid();
        testsRun++;
        if (spacingErr != 0) begin testsFailed++; $display("FAIL wr_spacing got %0d violations want 0", spacingErr); end
        $display("[TB] %0d tests run, %0d failed", testsRun, testsFailed);
        $finish;
    end

endmodule
